// File: rtl/trapezoid_if.sv
// Trapezoid membership bus: sampled crisp input and breakpoints in,
// registered membership degree and breakpoint-order flag out.
interface trapezoid_if #(
    parameter int unsigned MU_W = 16
);
    logic              in_valid;
    logic signed [7:0] x;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic signed [7:0] c;
    logic signed [7:0] d;
    logic              out_valid;
    logic [MU_W-1:0]   mu;
    logic              param_err;

    modport master (
        output in_valid, x, a, b, c, d,
        input  out_valid, mu, param_err
    );

    modport slave (
        input  in_valid, x, a, b, c, d,
        output out_valid, mu, param_err
    );
endinterface

// File: rtl/trapezoid.sv
// Trapezoidal fuzzy membership function, one-cycle latency, one result per cycle.
// Optional feature: define TRAPEZOID_PARAM_CHECK_EN to build the breakpoint-order
// check that drives param_err; otherwise param_err is tied low.
module trapezoid #(
    parameter int unsigned MU_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    trapezoid_if.slave  bus
);
    localparam int unsigned DIFF_W = 9;
    localparam int unsigned NUM_W  = 23;
    localparam int unsigned DEN_W  = 8;
    localparam int unsigned FRAC_W = 15;
    localparam int unsigned Q_W    = 16;
    localparam logic [Q_W-1:0] MU_ONE  = 16'h7FFF;
    localparam logic [Q_W-1:0] MU_ZERO = 16'h0000;

    logic signed [7:0] x_s, a_s, b_s, c_s, d_s;
    logic signed [DIFF_W-1:0] d_xa, d_ba, d_dx, d_dc;
    logic [Q_W-1:0]  mu_c;
    logic [MU_W-1:0] mu_q;
    logic            out_valid_q;

    assign x_s = bus.x;
    assign a_s = bus.a;
    assign b_s = bus.b;
    assign c_s = bus.c;
    assign d_s = bus.d;

    // Nine-bit differences cannot overflow for any 8-bit signed operand pair.
    assign d_xa = {x_s[7], x_s} - {a_s[7], a_s};
    assign d_ba = {b_s[7], b_s} - {a_s[7], a_s};
    assign d_dx = {d_s[7], d_s} - {x_s[7], x_s};
    assign d_dc = {d_s[7], d_s} - {c_s[7], c_s};

    // Unsigned truncating divide saturated to 1.0; a zero denominator yields 1.0.
    function automatic logic [Q_W-1:0] sat_div(input logic [NUM_W-1:0] num,
                                               input logic [DEN_W-1:0] den);
        logic [NUM_W-1:0] q;
        logic [Q_W-1:0]   res;
        res = MU_ONE;
        if (den != '0) begin
            q = num / NUM_W'(den);
            if (q <= NUM_W'(MU_ONE)) begin
                res = q[Q_W-1:0];
            end
        end
        return res;
    endfunction

    // Region select, plateau first so degenerate breakpoints resolve to 1.0.
    always_comb begin
        mu_c = MU_ZERO;
        if (x_s >= b_s && x_s <= c_s) begin
            mu_c = MU_ONE;
        end else if (x_s <= a_s || x_s >= d_s) begin
            mu_c = MU_ZERO;
        end else if (x_s > a_s && x_s < b_s) begin
            mu_c = sat_div(NUM_W'($unsigned(d_xa)) << FRAC_W, DEN_W'($unsigned(d_ba)));
        end else if (x_s > c_s && x_s < d_s) begin
            mu_c = sat_div(NUM_W'($unsigned(d_dx)) << FRAC_W, DEN_W'($unsigned(d_dc)));
        end
    end

    // Result register: mu holds between samples, out_valid pulses per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mu_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                mu_q <= MU_W'(mu_c);
            end
        end
    end

    assign bus.mu        = mu_q;
    assign bus.out_valid = out_valid_q;

`ifdef TRAPEZOID_PARAM_CHECK_EN
    logic order_err_c;
    logic param_err_q;

    assign order_err_c = (a_s > b_s) || (b_s > c_s) || (c_s > d_s);

    // Breakpoint-order flag, updated alongside each result and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            param_err_q <= 1'b0;
        end else if (bus.in_valid) begin
            param_err_q <= order_err_c;
        end
    end

    assign bus.param_err = param_err_q;
`else
    assign bus.param_err = 1'b0;
`endif

endmodule

// File: tb/tb_trapezoid.sv
// Scoreboard bench for trapezoid: expectations queued at drive time, popped on out_valid.
module tb_trapezoid;
    localparam int unsigned MU_W = 16;

    typedef struct packed {
        logic [15:0] mu;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    logic [15:0] last_mu;

    trapezoid_if #(.MU_W(MU_W)) bus ();

    trapezoid #(.MU_W(MU_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input int av, input int bv, input int cv, input int dv);
`ifdef TRAPEZOID_PARAM_CHECK_EN
        return (av > bv) || (bv > cv) || (cv > dv);
`else
        return 1'b0;
`endif
    endfunction

    // Reference membership computed directly from the region definitions.
    function automatic logic [15:0] ref_mu(input int xv, input int av, input int bv,
                                           input int cv, input int dv);
        int q;
        if (xv >= bv && xv <= cv) return 16'h7FFF;
        if (xv <= av || xv >= dv) return 16'h0000;
        if (xv > av && xv < bv) q = ((xv - av) * 32768) / (bv - av);
        else if (dv != cv)      q = ((dv - xv) * 32768) / (dv - cv);
        else                    q = 32767;
        if (q > 32767) q = 32767;
        return 16'(q);
    endfunction

    task automatic drive(input int xv, input int av, input int bv, input int cv,
                         input int dv, input logic [15:0] emu, input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.x = 8'(xv);
        bus.a = 8'(av);
        bus.b = 8'(bv);
        bus.c = 8'(cv);
        bus.d = 8'(dv);
        e.mu  = emu;
        e.err = eerr;
        sb.push_back(e);
        last_mu = emu;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Output monitor: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mu", 32'(bus.mu), 32'(e.mu));
                check("param_err", 32'(bus.param_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Directed vectors: x, a, b, c, d, expected mu.
    int dir_v[12][6] = '{
        '{-127, -64,   0,  0,  64, 16'h0000},
        '{ -32, -64,   0,  0,  64, 16'h4000},
        '{  32, -64,   0,  0,  64, 16'h4000},
        '{   0, -64,   0,  0,  64, 16'h7FFF},
        '{ 127, -64,   0,  0,  64, 16'h0000},
        '{ -60, -100, -20, 20, 100, 16'h4000},
        '{  10, -100, -20, 20, 100, 16'h7FFF},
        '{-100, -100, -20, 20, 100, 16'h0000},
        '{  50, -100, -20, 20, 100, 16'h5000},
        '{ -10, -10, -10, 10,  10, 16'h7FFF},
        '{ -11, -10, -10, 10,  10, 16'h0000},
        '{   0,  10, -10, 20,  30, 16'h7FFF}
    };

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_mu  = 16'h0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        bus.d = '0;

        #12;
        check("rst_mu", 32'(bus.mu), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_param_err", 32'(bus.param_err), 32'h0);
        #10;
        rst_n = 1'b1;

        // Directed vectors back to back.
        for (int i = 0; i < 12; i++) begin
            drive(dir_v[i][0], dir_v[i][1], dir_v[i][2], dir_v[i][3], dir_v[i][4],
                  16'(dir_v[i][5]),
                  exp_err(dir_v[i][1], dir_v[i][2], dir_v[i][3], dir_v[i][4]));
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        check("idle_out_valid", 32'(bus.out_valid), 32'h0);
        check("idle_mu_hold", 32'(bus.mu), 32'(last_mu));

        // Random vectors, mostly ordered breakpoints, with occasional gaps.
        for (int i = 0; i < 300; i++) begin
            int v[4];
            int xv;
            for (int k = 0; k < 4; k++) v[k] = int'($urandom_range(255)) - 128;
            if (i % 4 != 0) begin
                for (int p = 0; p < 3; p++)
                    for (int q = 0; q < 3 - p; q++)
                        if (v[q] > v[q+1]) begin
                            int t;
                            t = v[q]; v[q] = v[q+1]; v[q+1] = t;
                        end
            end
            xv = int'($urandom_range(255)) - 128;
            drive(xv, v[0], v[1], v[2], v[3], ref_mu(xv, v[0], v[1], v[2], v[3]),
                  exp_err(v[0], v[1], v[2], v[3]));
            if ($urandom_range(3) == 0) idle();
        end
        idle();
        repeat (3) @(negedge clk);
        check("sb_drain_random", 32'(sb.size()), 32'd0);

        // Five back-to-back samples, then reset while a sixth is in flight.
        for (int i = 0; i < 5; i++) begin
            drive(dir_v[i][0], dir_v[i][1], dir_v[i][2], dir_v[i][3], dir_v[i][4],
                  16'(dir_v[i][5]), 1'b0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.x = 8'(-32);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_mu", 32'(bus.mu), 32'h0);
        check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_param_err", 32'(bus.param_err), 32'h0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hold_out_valid", 32'(bus.out_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("sb_drain_reset", 32'(sb.size()), 32'd0);

        // First sample after reset release.
        drive(-60, -100, -20, 20, 100, 16'h4000, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        check("sb_drain_final", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
